// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU bus: decoder/operand inputs and combinational/registered results.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp;
    logic            funct7_30;
    logic [2:0]      funct3;
    logic            Lui;
    logic            Auipc;
    logic [XLEN-1:0] readData1_R;
    logic [XLEN-1:0] PCaddress;
    logic [XLEN-1:0] aluB;

    logic [3:0]      aluControl;
    logic [XLEN-1:0] aluA;
    logic [XLEN-1:0] aluResult;
    logic            zero;
    logic            s_less;
    logic            u_less;
    logic [XLEN-1:0] aluResult_q;
    logic            zero_q;
    logic            s_less_q;
    logic            u_less_q;

    // Decode/operand source side (core control path, or a testbench)
    modport master (
        output ALUOp, funct7_30, funct3, Lui, Auipc, readData1_R, PCaddress, aluB,
        input  aluControl, aluA, aluResult, zero, s_less, u_less,
        input  aluResult_q, zero_q, s_less_q, u_less_q
    );

    // ALU side
    modport slave (
        input  ALUOp, funct7_30, funct3, Lui, Auipc, readData1_R, PCaddress, aluB,
        output aluControl, aluA, aluResult, zero, s_less, u_less,
        output aluResult_q, zero_q, s_less_q, u_less_q
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: operation decode, operand-A select, result and
// compare flags (combinational), plus a registered copy for trace/debug.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst_n,
    alu_exec_unit_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    alu_op_e         op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;

    // Combinational results double as next-state for the trace registers
    logic [XLEN-1:0] res_d;
    logic            zero_d;
    logic            s_less_d;
    logic            u_less_d;

    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            s_less_q;
    logic            u_less_q;

    // Decode ALU class and funct fields into a concrete operation
    always_comb begin
        op = OP_ADD;
        unique case (bus.ALUOp)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                // R-type and I-type share the funct3 map; bit 30 selects SUB
                // only for R-type, since in I-type ADDI it is an immediate bit.
                unique case (bus.funct3)
                    3'b000: op = (bus.ALUOp == 2'b10 && bus.funct7_30) ? OP_SUB : OP_ADD;
                    3'b001: op = OP_SLL;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: op = bus.funct7_30 ? OP_SRA : OP_SRL;
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
        endcase
    end

    // Operand A: LUI forces zero and overrides AUIPC's PC selection
    always_comb begin
        op_a = bus.readData1_R;
        if (bus.Lui) begin
            op_a = '0;
        end else if (bus.Auipc) begin
            op_a = bus.PCaddress;
        end
    end

    assign op_b  = bus.aluB;
    assign shamt = op_b[SHW-1:0];

    // Compare flags are independent of the selected operation
    assign s_less_d = $signed(op_a) < $signed(op_b);
    assign u_less_d = op_a < op_b;

    // Result datapath
    always_comb begin
        res_d = '0;
        case (op)
            OP_ADD:  res_d = op_a + op_b;
            OP_SUB:  res_d = op_a - op_b;
            OP_SLL:  res_d = op_a << shamt;
            OP_SLT:  res_d = {{(XLEN-1){1'b0}}, s_less_d};
            OP_SLTU: res_d = {{(XLEN-1){1'b0}}, u_less_d};
            OP_XOR:  res_d = op_a ^ op_b;
            OP_SRL:  res_d = op_a >> shamt;
            OP_SRA:  res_d = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   res_d = op_a | op_b;
            OP_AND:  res_d = op_a & op_b;
            default: res_d = '0;
        endcase
    end

    assign zero_d = (res_d == '0);

    // Trace registers: capture every cycle, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            zero_q   <= 1'b0;
            s_less_q <= 1'b0;
            u_less_q <= 1'b0;
        end else begin
            res_q    <= res_d;
            zero_q   <= zero_d;
            s_less_q <= s_less_d;
            u_less_q <= u_less_d;
        end
    end

    assign bus.aluControl  = op;
    assign bus.aluA        = op_a;
    assign bus.aluResult   = res_d;
    assign bus.zero        = zero_d;
    assign bus.s_less      = s_less_d;
    assign bus.u_less      = u_less_d;
    assign bus.aluResult_q = res_q;
    assign bus.zero_q      = zero_q;
    assign bus.s_less_q    = s_less_q;
    assign bus.u_less_q    = u_less_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors with hand-derived
// expectations, reset behaviour, and back-to-back random traffic vs a model.
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        u;
    } exp_t;

    typedef struct {
        logic [1:0]  aluop;
        logic        f7;
        logic [2:0]  f3;
        logic        lui;
        logic        auipc;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t sb[$];     // combinational expectations
    exp_t sb_q[$];   // registered expectations (one cycle later)

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mkv(logic [1:0] aluop, logic f7, logic [2:0] f3,
                                 logic lui, logic auipc, logic [31:0] rs1,
                                 logic [31:0] pc, logic [31:0] b,
                                 logic [3:0] ctl, logic [31:0] a, logic [31:0] res,
                                 logic z, logic s, logic u);
        vec_t v;
        v.aluop = aluop; v.f7 = f7; v.f3 = f3; v.lui = lui; v.auipc = auipc;
        v.rs1 = rs1; v.pc = pc; v.b = b;
        v.e.ctl = ctl; v.e.a = a; v.e.res = res; v.e.z = z; v.e.s = s; v.e.u = u;
        return v;
    endfunction

    // Instruction-level reference: pick the mnemonic, then evaluate it
    function automatic exp_t model(vec_t v);
        exp_t e;
        string m;
        logic [31:0] r;
        int sh;
        e.a = v.lui ? 32'h0 : (v.auipc ? v.pc : v.rs1);
        if (v.aluop == 2'b00)      m = "add";
        else if (v.aluop == 2'b01) m = "sub";
        else begin
            case (v.f3)
                3'd0: m = (v.aluop == 2'b10 && v.f7) ? "sub" : "add";
                3'd1: m = "sll";
                3'd2: m = "slt";
                3'd3: m = "sltu";
                3'd4: m = "xor";
                3'd5: m = v.f7 ? "sra" : "srl";
                3'd6: m = "or";
                default: m = "and";
            endcase
        end
        sh = int'(v.b[4:0]);
        e.s = (e.a[31] != v.b[31]) ? e.a[31] : (e.a < v.b);
        e.u = (e.a < v.b);
        r = e.a;
        case (m)
            "add":  begin e.ctl = 4'd0; r = e.a + v.b; end
            "sub":  begin e.ctl = 4'd1; r = e.a + ~v.b + 32'd1; end
            "sll":  begin e.ctl = 4'd2; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
            "slt":  begin e.ctl = 4'd3; r = e.s ? 32'd1 : 32'd0; end
            "sltu": begin e.ctl = 4'd4; r = e.u ? 32'd1 : 32'd0; end
            "xor":  begin e.ctl = 4'd5; r = e.a ^ v.b; end
            "srl":  begin e.ctl = 4'd6; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
            "sra":  begin e.ctl = 4'd7; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
            "or":   begin e.ctl = 4'd8; r = e.a | v.b; end
            default: begin e.ctl = 4'd9; r = e.a & v.b; end
        endcase
        e.res = r;
        e.z = (r == 32'h0);
        return e;
    endfunction

    // Drive one vector and queue its expectation for both output stages
    task automatic drive(vec_t v);
        bus.ALUOp       = v.aluop;
        bus.funct7_30   = v.f7;
        bus.funct3      = v.f3;
        bus.Lui         = v.lui;
        bus.Auipc       = v.auipc;
        bus.readData1_R = v.rs1;
        bus.PCaddress   = v.pc;
        bus.aluB        = v.b;
        sb.push_back(v.e);
        sb_q.push_back(v.e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(mkv(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'd40, 32'd0, 32'd2,
                  4'd0, 32'd40, 32'd42, 1'b0, 1'b0, 1'b0));
        #3;
        e = sb.pop_front();
        void'(sb_q.pop_front());
        n_checks++;
        if ({bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_q: got res=%h z=%b s=%b u=%b, want all 0",
                     bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q);
        end
        n_checks++;
        if ({bus.aluControl, bus.aluA, bus.aluResult, bus.zero, bus.s_less, bus.u_less} !==
            {e.ctl, e.a, e.res, e.z, e.s, e.u}) begin
            n_fail++;
            $display("FAIL reset_comb: got ctl=%h a=%h res=%h, want ctl=%h a=%h res=%h",
                     bus.aluControl, bus.aluA, bus.aluResult, e.ctl, e.a, e.res);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vl[$];
        exp_t e;
        vl.push_back(mkv(2'b10,1,3'd0,0,0,32'd5,        32'h0,  32'd7,        4'd1,32'd5,        32'hFFFF_FFFE,0,1,1));
        vl.push_back(mkv(2'b11,1,3'd0,0,0,32'd10,       32'h0,  32'd3,        4'd0,32'd10,       32'd13,       0,0,0));
        vl.push_back(mkv(2'b11,1,3'd5,0,0,32'h8000_0000,32'h0,  32'h24,       4'd7,32'h8000_0000,32'hF800_0000,0,1,0));
        vl.push_back(mkv(2'b10,0,3'd2,0,0,32'hFFFF_FFFF,32'h0,  32'd1,        4'd3,32'hFFFF_FFFF,32'd1,        0,1,0));
        vl.push_back(mkv(2'b10,0,3'd3,0,0,32'hFFFF_FFFF,32'h0,  32'd1,        4'd4,32'hFFFF_FFFF,32'd0,        1,1,0));
        vl.push_back(mkv(2'b00,0,3'd0,0,1,32'h0000_AAAA,32'h100,32'h1000,     4'd0,32'h100,      32'h1100,     0,1,1));
        vl.push_back(mkv(2'b00,0,3'd0,1,1,32'h55,       32'h100,32'h1234_5000,4'd0,32'h0,        32'h1234_5000,0,1,1));
        vl.push_back(mkv(2'b01,1,3'd7,0,0,32'hDEAD_BEEF,32'h0,  32'hDEAD_BEEF,4'd1,32'hDEAD_BEEF,32'h0,        1,0,0));
        vl.push_back(mkv(2'b10,0,3'd5,0,0,32'h8000_0000,32'h0,  32'h24,       4'd6,32'h8000_0000,32'h0800_0000,0,1,0));
        vl.push_back(mkv(2'b10,0,3'd1,0,0,32'd1,        32'h0,  32'h3F,       4'd2,32'd1,        32'h8000_0000,0,1,1));
        vl.push_back(mkv(2'b11,1,3'd4,0,0,32'hF0F0_F0F0,32'h0,  32'h0FF0_0FF0,4'd5,32'hF0F0_F0F0,32'hFF00_FF00,0,1,0));
        vl.push_back(mkv(2'b10,0,3'd6,0,0,32'hF0F0_F0F0,32'h0,  32'h0F0F_0F0F,4'd8,32'hF0F0_F0F0,32'hFFFF_FFFF,0,1,0));
        vl.push_back(mkv(2'b11,0,3'd7,0,0,32'hF0F0_F0F0,32'h0,  32'h0F0F_0F0F,4'd9,32'hF0F0_F0F0,32'h0,        1,1,0));
        foreach (vl[k]) begin
            @(negedge clk);
            drive(vl[k]);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.aluControl, bus.aluA, bus.aluResult, bus.zero, bus.s_less, bus.u_less} !==
                {e.ctl, e.a, e.res, e.z, e.s, e.u}) begin
                n_fail++;
                $display("FAIL directed_comb[%0d]: got ctl=%h a=%h res=%h z=%b s=%b u=%b, want ctl=%h a=%h res=%h z=%b s=%b u=%b",
                         k, bus.aluControl, bus.aluA, bus.aluResult, bus.zero, bus.s_less, bus.u_less,
                         e.ctl, e.a, e.res, e.z, e.s, e.u);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q} !== {e.res, e.z, e.s, e.u}) begin
                n_fail++;
                $display("FAIL directed_q[%0d]: got res=%h z=%b s=%b u=%b, want res=%h z=%b s=%b u=%b",
                         k, bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q, e.res, e.z, e.s, e.u);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        drive(mkv(2'b10, 0, 3'd0, 0, 0, 32'h1111_0000, 32'h0, 32'h0000_2222,
                  4'd0, 32'h1111_0000, 32'h1111_2222, 0, 0, 0));
        e = sb.pop_front();
        void'(sb_q.pop_front());
        @(posedge clk);
        #3;
        n_checks++;
        if (bus.aluResult_q !== e.res) begin
            n_fail++;
            $display("FAIL pre_reset_q: got %h, want %h", bus.aluResult_q, e.res);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q} !== 35'h0) begin
            n_fail++;
            $display("FAIL async_clear_q: got res=%h, want 0", bus.aluResult_q);
        end
        n_checks++;
        if (bus.aluResult !== e.res) begin
            n_fail++;
            $display("FAIL comb_in_reset: got %h, want %h", bus.aluResult, e.res);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.aluResult_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold_q: got %h, want 0", bus.aluResult_q);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.aluResult_q !== 32'h0) begin
            n_fail++;
            $display("FAIL release_q: got %h, want 0 until next edge", bus.aluResult_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q} !== {e.res, e.z, e.s, e.u}) begin
            n_fail++;
            $display("FAIL first_capture_q: got res=%h, want %h", bus.aluResult_q, e.res);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v;
        exp_t e;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            v.aluop = 2'($urandom_range(0, 3));
            v.f7    = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            v.lui   = ($urandom_range(0, 7) == 0);
            v.auipc = ($urandom_range(0, 5) == 0);
            v.rs1   = $urandom();
            v.pc    = $urandom();
            v.b     = (k % 5 == 0) ? v.rs1 : $urandom();
            v.e     = model(v);
            drive(v);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({bus.aluControl, bus.aluA, bus.aluResult, bus.zero, bus.s_less, bus.u_less} !==
                {e.ctl, e.a, e.res, e.z, e.s, e.u}) begin
                n_fail++;
                $display("FAIL b2b_comb[%0d]: got ctl=%h a=%h res=%h z=%b s=%b u=%b, want ctl=%h a=%h res=%h z=%b s=%b u=%b",
                         k, bus.aluControl, bus.aluA, bus.aluResult, bus.zero, bus.s_less, bus.u_less,
                         e.ctl, e.a, e.res, e.z, e.s, e.u);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q} !== {e.res, e.z, e.s, e.u}) begin
                n_fail++;
                $display("FAIL b2b_q[%0d]: got res=%h z=%b s=%b u=%b, want res=%h z=%b s=%b u=%b",
                         k, bus.aluResult_q, bus.zero_q, bus.s_less_q, bus.u_less_q, e.res, e.z, e.s, e.u);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage datapath of the single-cycle RV32I core: decodes the 4-bit ALU operation from the main-decoder `ALUOp` and instruction funct fields, selects operand A (rs1 / PC / zero), and computes the 32-bit result plus the compare flags used by branch resolution. Outputs are combinational for same-cycle use by PCNext, Branch, Mem and RegWrite logic. A registered copy is also provided for trace and debug.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is required to work.

Ports:
- `clk`  in  1  clock; registered outputs update on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; clears registered outputs.
- `ALUOp`  in  2  main-decoder ALU class: 00 add, 01 branch/sub, 10 R-type, 11 I-type ALU.
- `funct7_30`  in  1  instruction bit 30.
- `funct3`  in  3  instruction bits 14:12.
- `Lui`  in  1  operand A forced to 0.
- `Auipc`  in  1  operand A = PC.
- `readData1_R`  in  32  rs1 value.
- `PCaddress`  in  32  current PC.
- `aluB`  in  32  operand B, already muxed between rs2 and imm.
- `aluControl`  out  4  decoded operation (combinational).
- `aluA`  out  32  selected operand A (combinational).
- `aluResult`  out  32  result (combinational).
- `zero`  out  1  aluResult == 0.
- `s_less`  out  1  signed aluA < aluB.
- `u_less`  out  1  unsigned aluA < aluB.
- `aluResult_q`, `zero_q`, `s_less_q`, `u_less_q`  out  32/1/1/1  registered copies.

## Operation
- Operand A: `Lui`=1 gives 0, which has priority over `Auipc`. Otherwise `Auipc`=1 gives `PCaddress`. Otherwise A is `readData1_R`.
- aluControl codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND. Codes 1010–1111 are unused and produce result 0.
- ALUOp 00: ADD, regardless of funct fields. Used for loads, stores, LUI, AUIPC, JAL and JALR.
- ALUOp 01: SUB, regardless of funct fields. Used for branches.
- ALUOp 10 (R-type), decoded by funct3:
  - 000: ADD, or SUB if funct7_30=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if funct7_30=1.
  - 110: OR.
  - 111: AND.
- ALUOp 11 (I-type): same as R-type, except funct3=000 is always ADD (bit 30 is an immediate bit). funct7_30 is honoured only for funct3=101 (SRAI).
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; no overflow flag.
  - Shifts use `aluB[4:0]` only. SRA replicates bit 31.
  - SLT/SLTU produce 32'h0000_0001 or 0.
- Flags:
  - `zero` is derived from `aluResult`.
  - `s_less` and `u_less` are computed from `aluA`/`aluB` for every operation, not only SLT/SLTU.

## Timing
- All non-`_q` outputs are purely combinational, with zero-cycle latency from any input.
- The block has no state other than the `_q` registers.
- `_q` registers capture `aluResult`/`zero`/`s_less`/`u_less` on every rising `clk`, with one-cycle latency.
- `rst_n` low asynchronously forces all `_q` outputs to 0 immediately and holds them there.
- `rst_n` deasserted: the first capture happens on the next rising edge.
- Reset mid-operation does not affect the combinational outputs.
- Both `Lui` and `Auipc` asserted: the Lui path wins, giving A = 0.

## Test plan
- ALUOp=10, funct3=000, funct7_30=1, A=5, B=7 -> aluControl=0001, result=32'hFFFF_FFFE, zero=0, s_less=1, u_less=1.
- ALUOp=11, funct3=000, funct7_30=1, A=10, B=3 -> ADD, result=13. Then funct3=101, funct7_30=1, A=32'h8000_0000, B=32'h24 -> SRA by 4, result=32'hF800_0000.
- ALUOp=10, SLT/SLTU with A=32'hFFFF_FFFF, B=1 -> SLT result=1, SLTU result=0; s_less=1, u_less=0.
- Auipc=1, PC=32'h100, ALUOp=00, B=32'h1000 -> aluA=32'h100, result=32'h1100. Lui=1 and Auipc=1, B=32'h12345000 -> result=32'h12345000.
- ALUOp=01, A=B=32'hDEADBEEF -> result 0, zero=1, s_less=0, u_less=0.
- rst_n pulsed low between clock edges -> `_q` outputs go to 0 at once. First rising edge after release -> `_q` equals the combinational values.
